sseg_scan_ctrl: RTL
===================

# sseg_scan_ctrl

Time-multiplexed scan controller for the Basys3 4-digit seven-segment display. It replaces the fixed single-digit drive (`an` tied to one digit) with a scheduler that shares the common `seg`/`dp` lines between all four digits. The display value is double-buffered through a valid/ready load port, so CPU-side values (e.g. `reg5_val[15:0]`) never tear mid-frame. It sits in the board top, between the core's debug outputs and the `seg`/`an`/`dp` pins.

## Interface
- `SCAN_DIV`, default 100000: `clk` cycles per digit slot (1 kHz per digit at 100 MHz). Must be ≥ 2.
- `BLANK_CYC`, default 1000: dead-time cycles at the start of each slot, with all anodes off (anti-ghosting). Must be < `SCAN_DIV`.
- `clk`  in  1  system clock (`CLK100MHZ` at top).
- `reset_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  producer offers `load_value`/`load_dp`.
- `load_ready`  out  1  high when the shadow buffer is free.
- `load_value`  in  16  four hex nibbles; nibble 0 maps to the rightmost digit (`an[0]`).
- `load_dp`  in  4  per-digit decimal point enable, active-high.
- `blank_i`  in  4  per-digit force-off mask, live (not buffered).
- `lz_suppress`  in  1  leading-zero suppression enable, live.
- `seg`  out  7  active-low segments; `seg[0]`=a … `seg[6]`=g.
- `an`  out  4  active-low anodes.
- `dp`  out  1  active-low decimal point.
- `frame_start`  out  1  one-cycle pulse marking a frame start.

## Operation
- **Slot counter.** `cnt` runs 0..`SCAN_DIV`-1. At `SCAN_DIV`-1 it wraps to 0 and digit index `d` increments, wrapping from 3 to 0. A frame is 4·`SCAN_DIV` cycles.
- **Buffers.**
  - `shadow` holds the accepted load; `active` holds what is displayed.
  - `pending` flags that `shadow` holds data not yet displayed.
  - `load_ready` = !`pending`.
  - A handshake (`load_valid` && `load_ready`) loads `shadow` and sets `pending`.
- **Transfer.** On the wrap edge (`d`=3, `cnt`=`SCAN_DIV`-1), if `pending`: `active` ← `shadow` and `pending` is cleared. The new value is therefore visible from the first cycle of digit-0's slot.
- **Load on the wrap edge.** A handshake on the wrap edge itself (only possible when `pending`=0) fills `shadow`. That data displays one frame later, not in the frame just starting.
- **Digit on/off.** Digit `d` is on unless any of these holds:
  - `cnt` < `BLANK_CYC`;
  - `blank_i[d]` is set;
  - `lz_suppress` is set, `d` ≠ 0, and nibbles `d`..3 of `active` are all zero.
  
  Digit 0 is never suppressed by `lz_suppress`.
- **Digit on:** `an` = ~(1<<`d`), `seg` = hex decode of nibble `d`, `dp` = ~`load_dp[d]` (as held in `active`).
- **Digit off:** `an`=4'hF, `seg`=7'h7F, `dp`=1.

## Timing
- `seg`, `an`, `dp` and `frame_start` are registered, with 1 cycle latency from counter/`active` state.
- `frame_start` is high in the cycle after the counter state (`d`=0, `cnt`=0).
- `load_ready` is combinational from the `pending` flop. It is low from the cycle after acceptance until the cycle after the next wrap edge.
- **Reset (async, immediate):**
  - `cnt`=0, `d`=0, `active`=0, `shadow`=0, `pending`=0;
  - `an`=4'hF, `seg`=7'h7F, `dp`=1, `frame_start`=0, `load_ready`=1.
- **Reset mid-frame** discards any pending load. After release the scan restarts at digit 0 with `active`=0.
- **Live inputs:** `blank_i` and `lz_suppress` changes take effect on the next output register update (no frame alignment).
- **Counter width** is $clog2(`SCAN_DIV`). No other arithmetic beyond the wrap increments.

## Structure
- Shared package holds:
  - `NUM_DIGITS`=4;
  - segment constants `SEG_OFF`=7'h7F and `AN_OFF`=4'hF;
  - the default `SCAN_DIV`/`BLANK_CYC` values for 100 MHz.
- Sub-module: the existing combinational `seven_seg_hex` decoder, instantiated once on the muxed nibble.
- All sequencing (counter, buffers, output registers) lives in `sseg_scan_ctrl`.

## Test plan
All scenarios use `SCAN_DIV`=8 and `BLANK_CYC`=2.
- **Reset:** assert `reset_n`=0 mid-slot → `an`=4'hF, `seg`=7'h7F, `dp`=1 asynchronously; `load_ready`=1. After release, `frame_start` pulses in the 2nd cycle, and digit 0 shows `seg`=7'h40 ('0') from cycle 3.
- **Double-buffered load:** load 16'h1234 at `cnt`=5 of digit 1 → `load_ready`=0 and the display keeps 0000 until the wrap. In the next frame:
  - digit 0 slot: `an`=4'b1110, `seg`=7'h19 ('4'), after 2 blank cycles;
  - digit 3 slot: `an`=4'b0111, `seg`=7'h79 ('1');
  - `load_ready` returns to 1 the cycle after the wrap.
- **Back-to-back loads:** hold `load_valid` with A=16'hAAAA, then B=16'hBBBB → A is accepted immediately. B is accepted only the cycle after the wrap and appears one frame after A.
- **Leading-zero suppression:** `lz_suppress`=1, value 16'h0050 → `an` stays 4'hF in the digit 3 and 2 slots; digit 1 shows `seg`=7'h12 ('5'); digit 0 shows '0'. With value 16'h0000, only digit 0 lights.
- **Masks:** `load_dp`=4'b0100, `blank_i`=4'b0001 → `dp`=0 only in the digit 2 slot (non-blank cycles); `an`=4'hF throughout the digit 0 slot.
- **Reset with pending load:** reset during the digit 2 slot with `pending`=1 → after release the display shows 0000 and `load_ready`=1.

Source files
------------

// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared constants and payload types for the seven-segment scan controller.
package sseg_scan_ctrl_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = $clog2(NUM_DIGITS);
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned VALUE_W    = NUM_DIGITS * NIBBLE_W;
    localparam int unsigned SEG_W      = 7;

    // Active-low "everything dark" patterns.
    localparam logic [SEG_W-1:0]      SEG_OFF = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'hF;

    // Defaults for a 100 MHz clock: 1 kHz per digit slot, 10 us dead time.
    localparam int unsigned DEFAULT_SCAN_DIV  = 100000;
    localparam int unsigned DEFAULT_BLANK_CYC = 1000;

    // One display word: four hex nibbles plus per-digit decimal points.
    typedef struct packed {
        logic [VALUE_W-1:0]    value;
        logic [NUM_DIGITS-1:0] dp;
    } disp_word_t;

endpackage

// File: rtl/sseg_scan_ctrl_hex.sv
// Combinational hex-to-seven-segment decoder, active-low, seg_c[0]=a .. seg_c[6]=g.
module seven_seg_hex
    import sseg_scan_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] hex,
    output logic [SEG_W-1:0]    seg_c
);

    // Glyph lookup for 0-9, A, b, C, d, E, F.
    always_comb begin
        seg_c = SEG_OFF;
        case (hex)
            4'h0: seg_c = 7'h40;
            4'h1: seg_c = 7'h79;
            4'h2: seg_c = 7'h24;
            4'h3: seg_c = 7'h30;
            4'h4: seg_c = 7'h19;
            4'h5: seg_c = 7'h12;
            4'h6: seg_c = 7'h02;
            4'h7: seg_c = 7'h78;
            4'h8: seg_c = 7'h00;
            4'h9: seg_c = 7'h10;
            4'hA: seg_c = 7'h08;
            4'hB: seg_c = 7'h03;
            4'hC: seg_c = 7'h46;
            4'hD: seg_c = 7'h21;
            4'hE: seg_c = 7'h06;
            4'hF: seg_c = 7'h0E;
            default: seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scan controller with a
// double-buffered load port so a displayed value never tears mid-frame.
module sseg_scan_ctrl
    import sseg_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = DEFAULT_SCAN_DIV,
    parameter int unsigned BLANK_CYC = DEFAULT_BLANK_CYC
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [VALUE_W-1:0]    load_value,
    input  logic [NUM_DIGITS-1:0] load_dp,
    input  logic [NUM_DIGITS-1:0] blank_i,
    input  logic                  lz_suppress,
    output logic [SEG_W-1:0]      seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  dp,
    output logic                  frame_start
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0]   cnt;
    logic [DIGIT_W-1:0] d;
    disp_word_t         shadow;
    disp_word_t         active;
    logic               pending;

    logic                slot_wrap_c;
    logic                frame_wrap_c;
    logic                load_fire_c;
    logic [NIBBLE_W-1:0] nibble_c;
    logic                upper_zero_c;
    logic                digit_on_c;
    logic [SEG_W-1:0]    hex_seg_c;

    assign slot_wrap_c  = (cnt == CNT_W'(SCAN_DIV - 1));
    assign frame_wrap_c = slot_wrap_c && (d == DIGIT_W'(NUM_DIGITS - 1));
    assign load_ready   = !pending;
    assign load_fire_c  = load_valid && !pending;

    // Select the current digit's nibble and detect whether it and all higher nibbles are zero.
    always_comb begin
        nibble_c     = '0;
        upper_zero_c = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (DIGIT_W'(i) == d) begin
                nibble_c = active.value[i*NIBBLE_W +: NIBBLE_W];
            end
            if ((DIGIT_W'(i) >= d) && (active.value[i*NIBBLE_W +: NIBBLE_W] != '0)) begin
                upper_zero_c = 1'b0;
            end
        end
    end

    // A digit lights outside the dead time unless masked or suppressed as a leading zero.
    always_comb begin
        digit_on_c = (cnt >= CNT_W'(BLANK_CYC))
                     && !blank_i[d]
                     && !(lz_suppress && (d != '0) && upper_zero_c);
    end

    seven_seg_hex u_hex (
        .hex   (nibble_c),
        .seg_c (hex_seg_c)
    );

    // Slot counter and digit index; the digit advances on every slot wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            d   <= '0;
        end else if (slot_wrap_c) begin
            cnt <= '0;
            d   <= frame_wrap_c ? '0 : d + DIGIT_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Double buffer: shadow takes loads, active is swapped in only on the frame wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else if (frame_wrap_c && pending) begin
            active  <= shadow;
            pending <= 1'b0;
        end else if (load_fire_c) begin
            shadow.value <= load_value;
            shadow.dp    <= load_dp;
            pending      <= 1'b1;
        end
    end

    // Registered pin drive, one cycle behind the counter and active buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an          <= AN_OFF;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (cnt == '0) && (d == '0);
            if (digit_on_c) begin
                an  <= ~(NUM_DIGITS'(1) << d);
                seg <= hex_seg_c;
                dp  <= ~active.dp[d];
            end else begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end
        end
    end

endmodule
